// File: rtl/skintone_pixel_issuer_pkg.sv
// Shared widths, pixel field offsets, score fixed-point format and issuer state encoding.
// SKINTONE_STATS_EN adds the statistics counter width used by the optional skin_count port.
package skintone_pixel_issuer_pkg;

  // Pixel is packed {Y, Cr, Cb}, 8 bits per channel, Cb in the low byte.
  localparam int CHAN_W = 8;
  localparam int CB_LSB = 0;
  localparam int CR_LSB = CB_LSB + CHAN_W;
  localparam int Y_LSB  = CR_LSB + CHAN_W;
  localparam int PIX_W  = Y_LSB + CHAN_W;

  // Skin score is an unsigned Q0.8 likelihood; zero means "not skin".
  localparam int SCORE_FRAC_BITS = 8;
  localparam int SCORE_W         = SCORE_FRAC_BITS;

`ifdef SKINTONE_STATS_EN
  localparam int STAT_W = 32;
`endif

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } issuer_state_e;

endpackage

// File: rtl/skintone_score_fifo.sv
// Result FIFO for returned skin scores: wrap-around pointers, show-ahead head, occupancy count.
// Simultaneous push and pop is legal at any occupancy, including full.
module skintone_score_fifo
  import skintone_pixel_issuer_pkg::*;
#(
  parameter int DEPTH = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [SCORE_W-1:0]       din,
  input  logic                     pop,
  output logic [SCORE_W-1:0]       dout,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [SCORE_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]      r_wr_ptr;
  logic [AW-1:0]      r_rd_ptr;
  logic [AW:0]        r_count;
  logic               w_full;
  logic               w_do_push;
  logic               w_do_pop;

  assign empty     = (r_count == '0);
  assign w_full    = (r_count == (AW+1)'(DEPTH));
  assign w_do_pop  = pop && !empty;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign w_do_push = push && (!w_full || w_do_pop);

  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Stale RAM contents are masked so the output reads zero whenever nothing is buffered.
  assign dout  = empty ? '0 : r_mem[r_rd_ptr];
  assign count = r_count;

endmodule

// File: rtl/skintone_pixel_issuer.sv
// Issues host pixels to a fixed-latency skin-score datapath and buffers returned scores.
// Optional feature: define SKINTONE_STATS_EN to add the skin_count statistics output.
module skintone_pixel_issuer
  import skintone_pixel_issuer_pkg::*;
#(
  parameter int FIFO_DEPTH = 32,
  parameter int DP_LATENCY = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic                 flush,
  input  logic [PIX_W-1:0]     s_pixel,
  input  logic                 s_valid,
  output logic                 s_ready,
  output logic [PIX_W-1:0]     dp_pixel,
  output logic                 dp_valid,
  input  logic [SCORE_W-1:0]   dp_result,
  input  logic                 dp_result_valid,
  output logic [SCORE_W-1:0]   m_score,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic                 busy,
  output logic                 flush_done,
  output logic                 protocol_err
`ifdef SKINTONE_STATS_EN
  ,
  output logic [STAT_W-1:0]    skin_count
`endif
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  generate
    if (FIFO_DEPTH < 2 * DP_LATENCY || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
      $error("FIFO_DEPTH must be a power of two and at least 2*DP_LATENCY");
    end
  endgenerate

  issuer_state_e      r_state;
  issuer_state_e      w_state_next;
  logic [CNT_W-1:0]   r_inflight;
  logic [CNT_W-1:0]   w_fifo_count;
  logic [CNT_W:0]     w_committed;
  logic               r_dp_valid;
  logic [PIX_W-1:0]   r_dp_pixel;
  logic               r_protocol_err;
  logic               w_hs;
  logic               w_fifo_push;
  logic               w_fifo_pop;
  logic               w_fifo_empty;
  logic               w_stray;
  logic               w_drained;

  // A pixel accepted last cycle is not yet in r_inflight, so it is reserved via r_dp_valid.
  assign w_committed = {1'b0, r_inflight} + {1'b0, w_fifo_count} + {{CNT_W{1'b0}}, r_dp_valid};
  assign s_ready     = (r_state == ST_RUN) && (w_committed < (CNT_W+1)'(FIFO_DEPTH));
  assign w_hs        = s_valid && s_ready;
  assign w_fifo_push = dp_result_valid && (r_inflight != '0);
  assign w_stray     = dp_result_valid && (r_inflight == '0);
  assign w_fifo_pop  = m_valid && m_ready;
  assign w_drained   = (r_inflight == '0) && w_fifo_empty && !r_dp_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:  if (enable)    w_state_next = ST_RUN;
      ST_RUN:   if (flush)     w_state_next = ST_DRAIN;
      ST_DRAIN: if (w_drained) w_state_next = ST_IDLE;
      default:                 w_state_next = ST_IDLE;
    endcase
  end

  assign busy       = (r_state != ST_IDLE);
  assign flush_done = (r_state == ST_DRAIN) && w_drained;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_dp_valid <= 1'b0;
      r_dp_pixel <= '0;
    end else begin
      r_dp_valid <= w_hs;
      if (w_hs) begin
        r_dp_pixel <= s_pixel;
      end
    end
  end

  assign dp_valid = r_dp_valid;
  assign dp_pixel = r_dp_pixel;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_inflight <= '0;
    end else begin
      case ({r_dp_valid, w_fifo_push})
        2'b10:   r_inflight <= r_inflight + 1'b1;
        2'b01:   r_inflight <= r_inflight - 1'b1;
        default: r_inflight <= r_inflight;
      endcase
    end
  end

  // A result with nothing outstanding is dropped and latched as an error until reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_protocol_err <= 1'b0;
    end else if (w_stray) begin
      r_protocol_err <= 1'b1;
    end
  end

  assign protocol_err = r_protocol_err;

  skintone_score_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (w_fifo_push),
    .din   (dp_result),
    .pop   (w_fifo_pop),
    .dout  (m_score),
    .empty (w_fifo_empty),
    .count (w_fifo_count)
  );

  assign m_valid = !w_fifo_empty;

`ifdef SKINTONE_STATS_EN
  logic [STAT_W-1:0] r_skin_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_skin_count <= '0;
    end else if (w_fifo_pop && (m_score != '0) && (r_skin_count != '1)) begin
      r_skin_count <= r_skin_count + 1'b1;
    end
  end

  assign skin_count = r_skin_count;
`endif

endmodule

// File: doc/skintone_pixel_issuer.md
SKINTONE_PIXEL_ISSUER -- requirements
Module: skintone_pixel_issuer

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 32, result FIFO entries; power of two, at least 2x DP_LATENCY.
REQ-002 SHALL have parameter DP_LATENCY, default 16, downstream datapath valid-to-result-valid cycles.
REQ-003 SHALL use one clock and a synchronous, active-high reset.
REQ-004 clk  in  1  rising-edge clock for all state.
REQ-005 rst  in  1  synchronous active-high reset.
REQ-006 enable  in  1  level; starts acceptance from IDLE.
REQ-007 flush  in  1  single-cycle pulse; stop acceptance and drain.
REQ-008 s_pixel  in  24  host pixel {Y[23:16], Cr[15:8], Cb[7:0]}.
REQ-009 s_valid / s_ready  in / out  1 each  host ready/valid handshake.
REQ-010 dp_pixel / dp_valid  out  24 / 1  pixel issue to datapath; no backpressure.
REQ-011 dp_result / dp_result_valid  in  8 / 1  skin score returned by datapath.
REQ-012 m_score / m_valid / m_ready  out / out / in  8 / 1 / 1  score output ready/valid.
REQ-013 busy  out  1  high when not IDLE.
REQ-014 flush_done  out  1  one-cycle pulse when DRAIN completes.
REQ-015 protocol_err  out  1  sticky error flag.

Function
REQ-016 SHALL implement the states IDLE, RUN and DRAIN.
REQ-017 IDLE->RUN when enable=1; RUN->DRAIN on flush; DRAIN->IDLE when inflight==0 and FIFO empty, with flush_done pulsed that cycle; flush in IDLE ignored.
REQ-018 SHALL hold inflight counter (log2(FIFO_DEPTH)+1 bits): +1 on dp_valid, -1 on dp_result_valid, unchanged when both.
REQ-019 s_ready SHALL be 1 only in RUN with inflight + fifo_count < FIFO_DEPTH; guarantees every issued pixel has a FIFO slot.
REQ-020 on s_valid&&s_ready, dp_pixel SHALL equal s_pixel and dp_valid SHALL be 1 exactly one cycle later; dp_valid=0 otherwise, dp_pixel holds last value.
REQ-021 on dp_result_valid with inflight>0, dp_result SHALL be written to FIFO; m_valid asserts no earlier than next cycle (no bypass).
REQ-022 dp_result_valid with inflight==0 SHALL set protocol_err and discard the result.
REQ-023 FIFO SHALL be first-in first-out with wrap-around pointers; push and pop in the same cycle leave fifo_count unchanged, including when full or when holding one entry.
REQ-024 m_score/m_valid SHALL remain stable while m_valid=1 and m_ready=0.
REQ-025 flush asserted in the same cycle as a host handshake: that pixel SHALL be issued and counted; no further acceptance.

Reset
REQ-026 rst SHALL force: state IDLE, inflight 0, FIFO empty, s_ready 0, dp_valid 0, dp_pixel 0, m_valid 0, m_score 0, busy 0, flush_done 0, protocol_err 0.
REQ-027 rst mid-operation SHALL discard in-flight and buffered results; results returning after reset SHALL set protocol_err.

Configuration
REQ-028 With SKINTONE_STATS_EN defined, SHALL add output skin_count (32 bits) counting popped scores that are non-zero, saturating at 0xFFFFFFFF, cleared by rst.
REQ-029 Without SKINTONE_STATS_EN, skin_count port and counter SHALL be absent; all other behaviour identical.

Structure
REQ-030 Pixel width 24, score width 8, field offsets and state encoding SHALL live in the shared datapath package/header alongside the fixed-point constants.
REQ-031 FIFO SHALL be a sub-module skintone_score_fifo (parameterised depth, 8-bit data, count output).

Verification
REQ-032 Single pixel 0x80_90_70 in RUN -> dp_valid one cycle after handshake with dp_pixel=0x809070; return 0x2A after 16 cycles -> m_score=0x2A, inflight back to 0.
REQ-033 m_ready held 0, continuous s_valid -> exactly 32 pixels accepted, then s_ready=0 until one pop.
REQ-034 Full FIFO, m_ready=1 and dp_result_valid same cycle -> fifo_count stays 32, order preserved across pointer wrap.
REQ-035 flush with 5 in flight -> s_ready=0 immediately, state DRAIN, flush_done pulses once after last score popped, busy=0 next cycle.
REQ-036 dp_result_valid while inflight==0 -> protocol_err=1, stays 1 until rst, FIFO unchanged.
REQ-037 With SKINTONE_STATS_EN: pop scores 0,5,0,255 -> skin_count=2.
